pfb_multichannel_decimator_mul_arbiter: RTL and testbench
=========================================================

# pfb_multichannel_decimator_mul_arbiter

Round-robin scheduler that lets up to NUM_REQ requesters share one unsigned A_WIDTH x B_WIDTH multiplier inside the PFB multichannel decimator, e.g. per-channel coefficient x sample products. It accepts one operand pair per cycle through per-requester valid/ready handshakes. The products pass through a two-stage registered pipeline and return on a single output stream, tagged with the requester index. Output backpressure stalls the pipeline without losing data.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- A_WIDTH, 11, unsigned operand A width
- B_WIDTH, 13, unsigned operand B width
- OUT_WIDTH, 23, output width, must satisfy OUT_WIDTH <= A_WIDTH+B_WIDTH
- ID_WIDTH, 2, requester tag width, must satisfy ID_WIDTH >= clog2(NUM_REQ)

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*A_WIDTH  operand A; requester i occupies bits [i*A_WIDTH +: A_WIDTH]
- req_b  in  NUM_REQ*B_WIDTH  operand B; same packing as req_a
- out_valid  out  1  product valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_WIDTH  scaled product
- out_id  out  ID_WIDTH  index of the requester that issued the product

## Operation
- Pipeline: stage S1 registers the selected operands and id. Stage S2 registers the full product P = A*B (A_WIDTH+B_WIDTH bits, unsigned, zero-extended) and the id.
- Stall rules:
  - adv2 = !v2 || out_ready
  - adv1 = !v1 || adv2
  - A stage with its advance low holds its register contents.
- Arbitration:
  - rr_ptr holds the last granted index.
  - Search order is rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. The grant goes to the first index with req_valid set.
  - req_ready[g] = adv1 for the granted index g; req_ready is 0 for every other index.
  - The handshake on requester g completes when req_valid[g] && req_ready[g]. Only then does rr_ptr load g.
- req_ready is combinational from req_valid, rr_ptr, v1, v2 and out_ready. Requesters must not make req_valid depend on req_ready.
- No valid requests: S1 loads a bubble (v1=0) when adv1 is high; rr_ptr is unchanged.
- Scaling: SHIFT = A_WIDTH+B_WIDTH-OUT_WIDTH (1 for the defaults). Without the Configuration macro, out_data = P >> SHIFT, i.e. the LSBs are truncated.
- Ordering: products leave in exactly grant order; no reordering and no drops.
- Reset, held for any number of cycles, including mid-operation:
  - v1, v2 and out_valid go to 0; out_data and out_id go to 0; rr_ptr goes to NUM_REQ-1, so requester 0 has first priority.
  - req_ready is 0 while ap_rst is high.
  - In-flight products are discarded.

## Timing
- Latency: a handshake in cycle N gives out_valid=1 at cycle N+2 when out_ready stays high.
- Throughput: one product per cycle sustained.
- out_valid, out_data and out_id are driven from registers.
- While out_valid && !out_ready, out_data and out_id hold stable.
- Full stall (v1 && v2 && !out_ready): all req_ready are 0 in the same cycle.
- First cycle after reset deassertion: grants are allowed (adv1=1).

## Configuration
- PFB_MUL_ARB_ROUND_EN defined: out_data = min((P + 2^(SHIFT-1)) >> SHIFT, 2^OUT_WIDTH-1), i.e. round half up with saturation. The rounding add sits in the S2 path and adds no cycle of latency. With SHIFT=0, out_data = P.
- PFB_MUL_ARB_ROUND_EN undefined: plain truncation P >> SHIFT; no adder is instantiated.

## Test plan
- Single request, defaults, truncation: requester 2 sends a=3, b=1 in cycle 5 with out_ready=1 -> out_valid in cycle 7 with out_data=1, out_id=2. With PFB_MUL_ARB_ROUND_EN -> out_data=2.
- Max operands: a=2047, b=8191 (P=0xFFD801) -> out_data=0x7FEC00 without the macro, 0x7FEC01 with it.
- Fairness: all four req_valid held high from the first cycle after reset for 8 cycles -> grant order 0,1,2,3,0,1,2,3; out_id follows the same sequence 2 cycles later.
- Backpressure: continuous requests, out_ready low for 3 cycles -> out_data/out_id stable throughout. Once S1 and S2 are full, req_ready=0 and rr_ptr is frozen. After out_ready rises, the sequence resumes with no lost or duplicated ids.
- Sparse requests: only requester 3 valid in alternate cycles -> every request is granted in the cycle it is presented. Bubbles propagate, and out_valid alternates.
- Reset mid-stream: assert ap_rst for 1 cycle with S1 and S2 full -> next cycle out_valid=0, out_data=0, out_id=0. The first grant after reset goes to requester 0 when all are valid.

Source files
------------

// File: rtl/pfb_multichannel_decimator_mul_arbiter_if.sv
// Operand-request / product-stream bundle for the shared PFB multiplier.
// The arbiter takes the slave side; requesters plus downstream sink take the master side.
interface pfb_multichannel_decimator_mul_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int A_WIDTH   = 11,
  parameter int B_WIDTH   = 13,
  parameter int OUT_WIDTH = 23,
  parameter int ID_WIDTH  = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_WIDTH-1:0]       out_data;
  logic [ID_WIDTH-1:0]        out_id;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/pfb_multichannel_decimator_mul_arbiter.sv
// Round-robin sharing of one unsigned multiplier across NUM_REQ requesters, two-stage pipeline.
// Optional macro PFB_MUL_ARB_ROUND_EN: round-half-up with saturation instead of truncation.
module pfb_multichannel_decimator_mul_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int A_WIDTH   = 11,
  parameter int B_WIDTH   = 13,
  parameter int OUT_WIDTH = 23,
  parameter int ID_WIDTH  = 2
) (
  input  logic ap_clk,
  input  logic ap_rst,
  pfb_multichannel_decimator_mul_arbiter_if.slave bus
);
  localparam int PW    = A_WIDTH + B_WIDTH;
  localparam int SHIFT = PW - OUT_WIDTH;
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [A_WIDTH-1:0] a_arr [NUM_REQ];
  logic [B_WIDTH-1:0] b_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.req_a[gi*A_WIDTH +: A_WIDTH];
      assign b_arr[gi] = bus.req_b[gi*B_WIDTH +: B_WIDTH];
    end
  endgenerate

  logic                 v1_q, v1_d;
  logic [A_WIDTH-1:0]   a1_q, a1_d;
  logic [B_WIDTH-1:0]   b1_q, b1_d;
  logic [PTR_W-1:0]     id1_q, id1_d;
  logic                 v2_q, v2_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]  id2_q, id2_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                 adv1, adv2, hs;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand;
  logic [NUM_REQ-1:0]   ready_c;
  logic [PW-1:0]        prod;
  logic [OUT_WIDTH-1:0] scaled;

  assign adv2 = !v2_q || bus.out_ready;
  assign adv1 = !v1_q || adv2;

  // First valid index strictly after the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign hs = grant_found && adv1 && !ap_rst;

  always_comb begin
    ready_c = '0;
    if (hs) ready_c[grant_idx] = 1'b1;
  end
  assign bus.req_ready = ready_c;

  assign prod = PW'(a1_q) * PW'(b1_q);

`ifdef PFB_MUL_ARB_ROUND_EN
  generate
    if (SHIFT == 0) begin : g_noshift
      assign scaled = prod;
    end else begin : g_round
      logic [PW:0] sum;
      logic [PW:0] shifted;
      assign sum     = {1'b0, prod} + ((PW+1)'(1) << (SHIFT-1));
      assign shifted = sum >> SHIFT;
      assign scaled  = (|shifted[PW:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];
    end
  endgenerate
`else
  assign scaled = OUT_WIDTH'(prod >> SHIFT);
`endif

  always_comb begin
    v1_d     = v1_q;
    a1_d     = a1_q;
    b1_d     = b1_q;
    id1_d    = id1_q;
    v2_d     = v2_q;
    data_d   = data_q;
    id2_d    = id2_q;
    rr_ptr_d = rr_ptr_q;
    if (adv1) begin
      v1_d  = hs;
      a1_d  = a_arr[grant_idx];
      b1_d  = b_arr[grant_idx];
      id1_d = grant_idx;
    end
    if (adv2) begin
      v2_d   = v1_q;
      data_d = scaled;
      id2_d  = ID_WIDTH'(id1_q);
    end
    if (hs) rr_ptr_d = grant_idx;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v1_q     <= 1'b0;
      a1_q     <= '0;
      b1_q     <= '0;
      id1_q    <= '0;
      v2_q     <= 1'b0;
      data_q   <= '0;
      id2_q    <= '0;
      rr_ptr_q <= PTR_W'(NUM_REQ - 1);
    end else begin
      v1_q     <= v1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      id1_q    <= id1_d;
      v2_q     <= v2_d;
      data_q   <= data_d;
      id2_q    <= id2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.out_data  = data_q;
  assign bus.out_id    = id2_q;
endmodule

// File: tb/tb_pfb_multichannel_decimator_mul_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
// Reference model follows PFB_MUL_ARB_ROUND_EN the same way the design does.
module tb_pfb_multichannel_decimator_mul_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int A_WIDTH   = 11;
  localparam int B_WIDTH   = 13;
  localparam int OUT_WIDTH = 23;
  localparam int ID_WIDTH  = 2;
  localparam int SHIFT     = A_WIDTH + B_WIDTH - OUT_WIDTH;
  localparam longint MAXO  = (longint'(1) << OUT_WIDTH) - 1;

  typedef struct {
    int     id;
    longint data;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pfb_multichannel_decimator_mul_arbiter_if #(
    .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH),
    .OUT_WIDTH(OUT_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) bus ();

  pfb_multichannel_decimator_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH),
    .OUT_WIDTH(OUT_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .bus   (bus)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  int     model_rr = NUM_REQ - 1;
  item_t  exp_q[$];
  int     grant_log[$];
  bit     hold_pending = 1'b0;
  longint held_data;
  int     held_id;
  logic   obs_valid;
  longint obs_data;
  int     obs_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint exp_scaled(input longint a, input longint b);
    longint p;
    longint r;
    p = a * b;
`ifdef PFB_MUL_ARB_ROUND_EN
    if (SHIFT == 0) r = p;
    else r = (p + (longint'(1) << (SHIFT - 1))) >> SHIFT;
    if (r > MAXO) r = MAXO;
`else
    r = p >> SHIFT;
`endif
    return r;
  endfunction

  task automatic set_req(input int i, input logic v, input int a, input int b);
    bus.req_valid[i] = v;
    bus.req_a[i*A_WIDTH +: A_WIDTH] = A_WIDTH'(a);
    bus.req_b[i*B_WIDTH +: B_WIDTH] = B_WIDTH'(b);
  endtask

  // One clock: checks at the falling edge, model update at the rising edge.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_ready;
    int     g;
    int     c;
    bit     acc;
    item_t  it;
    longint a_v;
    longint b_v;
    acc = 1'b0;
    g   = -1;
    @(negedge clk);
    obs_valid = bus.out_valid;
    obs_data  = longint'(bus.out_data);
    obs_id    = int'(bus.out_id);
    exp_ready = '0;
    if (rst) begin
      chk("ready_in_reset", 64'(bus.req_ready), 64'(0));
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (model_rr + k) % NUM_REQ;
        if (g < 0 && bus.req_valid[c]) g = c;
      end
      acc = (g >= 0) && (exp_q.size() < 2 || bus.out_ready);
      if (acc) exp_ready[g] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      if (hold_pending) begin
        chk("hold_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_data", 64'(bus.out_data), 64'(held_data));
        chk("hold_id", 64'(bus.out_id), 64'(held_id));
      end
      if (bus.out_valid) begin
        chk("out_has_item", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          chk("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
          chk("out_id", 64'(bus.out_id), 64'(exp_q[0].id));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      held_data    = longint'(bus.out_data);
      held_id      = int'(bus.out_id);
    end
    if (acc) begin
      a_v = longint'(bus.req_a[g*A_WIDTH +: A_WIDTH]);
      b_v = longint'(bus.req_b[g*B_WIDTH +: B_WIDTH]);
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      model_rr     = NUM_REQ - 1;
      hold_pending = 1'b0;
    end else if (acc) begin
      it.id   = g;
      it.data = exp_scaled(a_v, b_v);
      exp_q.push_back(it);
      model_rr = g;
      grant_log.push_back(g);
    end
    #1;
  endtask

  task automatic all_valid_random();
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 1'b1, int'($urandom_range(0, (1 << A_WIDTH) - 1)),
              int'($urandom_range(0, (1 << B_WIDTH) - 1)));
  endtask

  task automatic clear_req();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 0, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    clear_req();
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;

    // Reset state, then single request from requester 2 with 2-cycle latency
    cycle();
    chk("rst_out_valid", 64'(obs_valid), 64'(0));
    chk("rst_out_data", 64'(obs_data), 64'(0));
    chk("rst_out_id", 64'(obs_id), 64'(0));
    set_req(2, 1'b1, 3, 1);
    cycle();
    chk("single_grant", 64'(grant_log[$]), 64'(2));
    clear_req();
    cycle();
    chk("lat_n1_valid", 64'(obs_valid), 64'(0));
    cycle();
    chk("lat_n2_valid", 64'(obs_valid), 64'(1));
    chk("lat_n2_id", 64'(obs_id), 64'(2));
`ifdef PFB_MUL_ARB_ROUND_EN
    chk("lat_n2_data", 64'(obs_data), 64'(2));
`else
    chk("lat_n2_data", 64'(obs_data), 64'(1));
`endif

    // Max operands
    set_req(0, 1'b1, 2047, 8191);
    cycle();
    clear_req();
    cycle();
    cycle();
    chk("max_valid", 64'(obs_valid), 64'(1));
`ifdef PFB_MUL_ARB_ROUND_EN
    chk("max_data", 64'(obs_data), 64'h7FEC01);
`else
    chk("max_data", 64'(obs_data), 64'h7FEC00);
`endif

    // Fairness from the first cycle after reset
    rst = 1'b1;
    all_valid_random();
    cycle();
    rst = 1'b0;
    grant_log.delete();
    for (int i = 0; i < 8; i++) begin
      all_valid_random();
      cycle();
    end
    chk("fair_count", 64'(grant_log.size()), 64'(8));
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      chk("fair_grant", 64'(grant_log[i]), 64'(i % NUM_REQ));

    // Backpressure: continuous requests, out_ready low for 3 cycles
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      all_valid_random();
      cycle();
    end
    chk("bp_held", 64'(obs_valid), 64'(1));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      all_valid_random();
      cycle();
    end

    // Sparse: requester 3 only, alternate cycles
    clear_req();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        set_req(3, 1'b1, int'($urandom_range(0, 2047)), int'($urandom_range(0, 8191)));
        n = grant_log.size();
        cycle();
        chk("sparse_granted", 64'(grant_log.size()), 64'(n + 1));
        chk("sparse_id", 64'(grant_log[$]), 64'(3));
      end else begin
        clear_req();
        cycle();
      end
    end
    clear_req();
    repeat (3) cycle();

    // Reset mid-stream with both stages full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      all_valid_random();
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    all_valid_random();
    n = grant_log.size();
    cycle();
    chk("midrst_valid", 64'(obs_valid), 64'(0));
    chk("midrst_data", 64'(obs_data), 64'(0));
    chk("midrst_id", 64'(obs_id), 64'(0));
    chk("midrst_grant_made", 64'(grant_log.size()), 64'(n + 1));
    chk("midrst_first_grant", 64'(grant_log[$]), 64'(0));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NUM_REQ; r++)
        set_req(r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)),
                int'($urandom_range(0, 8191)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Drain with a bounded wait
    clear_req();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    cycle();
    chk("drain_idle", 64'(obs_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
